toggle_decoder: RTL and testbench
=================================

TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchronizer flops; legal range 2..4.
REQ-002 Parameter CNT_W, default 4, width of the pending-event counter; maximum pending count is MAX = 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tgl_in  input  1  toggle-encoded event level; each transition (0->1 or 1->0) is one event; may be asynchronous to clk.
REQ-006 evt_valid  output  1  at least one decoded event pending.
REQ-007 evt_ready  input  1  downstream accepts one event when evt_valid && evt_ready at a rising edge.
REQ-008 pend_cnt  output  CNT_W  number of events pending.
REQ-009 overflow  output  1  sticky flag: an event was dropped.
REQ-010 ovf_clr  input  1  clears overflow.
REQ-011 state  output  2  FSM state: 00 ARM, 01 IDLE, 10 PEND, 11 FULL.

Function
REQ-012 tgl_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is tgl_s.
REQ-013 Register tgl_p SHALL hold the previous tgl_s every cycle; an edge is tgl_s != tgl_p in IDLE, PEND or FULL.
REQ-014 Latency: a tgl_in change captured by the first sync flop at edge k SHALL make evt_valid high after edge k+SYNC_STAGES, given no other pending events.
REQ-015 ARM: entered on reset; lasts SYNC_STAGES+1 cycles; tgl_p tracks tgl_s; no edges counted; then -> IDLE. The initial tgl_in level never produces an event.
REQ-016 pend_cnt update per cycle: +1 on edge only, -1 on accept only, unchanged on edge with accept.
REQ-017 evt_valid SHALL equal (pend_cnt != 0) and be driven from registered state only.
REQ-018 evt_ready while evt_valid is low SHALL have no effect; pend_cnt never underflows.
REQ-019 FSM: IDLE -> PEND on edge; PEND -> IDLE when the count reaches 0; PEND -> FULL when the count reaches MAX; FULL -> PEND on an accept without an edge.
REQ-020 Edge in FULL with no accept in the same cycle: event dropped, pend_cnt stays MAX, overflow set at the next edge.
REQ-021 Edge in FULL with an accept in the same cycle: no drop, pend_cnt stays MAX, state stays FULL.
REQ-022 ovf_clr clears overflow next edge; a simultaneous new drop wins (overflow stays 1).
REQ-023 Consecutive edges on successive cycles SHALL each be counted; no coalescing.

Reset
REQ-024 rst high at a rising edge SHALL set sync chain and tgl_p to 0, pend_cnt 0, evt_valid 0, overflow 0, state ARM.
REQ-025 rst mid-operation SHALL discard all pending events and any in-flight synchronizer edge; ARM restarts after release.
REQ-026 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-027 Macro TOGGLE_DEC_ASSERT_EN defined: the block SHALL contain concurrent assertions, disabled while rst is high.
- evt_valid == (pend_cnt != 0).
- pend_cnt <= MAX.
- state == FULL iff pend_cnt == MAX outside ARM.
- No edge is counted in ARM.
- overflow rises only in FULL.
REQ-028 Macro undefined: no assertion code; port list and cycle behaviour identical.

Verification
REQ-029 rst high 3 cycles, tgl_in=1 throughout and after release -> state ARM for 3 cycles then IDLE, pend_cnt 0, no evt_valid.
REQ-030 SYNC_STAGES=2, single tgl_in 0->1, evt_ready=0 -> evt_valid high exactly 2 edges after capture, pend_cnt=1; one cycle of evt_ready -> pend_cnt 0, IDLE.
REQ-031 CNT_W=4, 17 toggles on successive cycles, evt_ready=0 -> pend_cnt 15, state FULL, overflow 1; then 15 accepts -> pend_cnt 0, overflow stays 1 until ovf_clr.
REQ-032 pend_cnt=15, edge and accept in the same cycle -> pend_cnt 15, overflow 0.
REQ-033 pend_cnt=5, assert rst for 1 cycle -> pend_cnt 0, evt_valid 0, overflow 0, state ARM.
REQ-034 Build with TOGGLE_DEC_ASSERT_EN and run REQ-029..033 -> zero assertion failures; rebuild without it -> identical output waveforms.

Source files
------------

// File: rtl/toggle_decoder.sv
// Toggle-encoded event decoder: synchronizes tgl_in, counts each level transition as an event,
// and hands events downstream via valid/ready. Define TOGGLE_DEC_ASSERT_EN to build in assertions.
module toggle_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgl_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [1:0]       state
);

  localparam int unsigned ARM_W = 3;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ARM  = 2'b00,
    ST_IDLE = 2'b01,
    ST_PEND = 2'b10,
    ST_FULL = 2'b11
  } state_e;

  state_e                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_tgl_p;
  logic [ARM_W-1:0]       r_arm_cnt;
  logic [CNT_W-1:0]       r_pend_cnt;
  logic                   r_evt_valid;
  logic                   r_overflow;

  logic                   w_tgl_s;
  logic                   w_edge;
  logic                   w_accept;
  logic                   w_drop;
  logic [CNT_W-1:0]       w_cnt_nxt;

  assign w_tgl_s  = r_sync[SYNC_STAGES-1];
  assign w_edge   = (r_state != ST_ARM) && (w_tgl_s != r_tgl_p);
  assign w_accept = r_evt_valid && evt_ready;
  assign w_drop   = w_edge && !w_accept && (r_pend_cnt == MAX);

  // Edge and accept together cancel; a saturated counter drops the edge instead of wrapping.
  always_comb begin
    w_cnt_nxt = r_pend_cnt;
    if (w_edge && !w_accept && (r_pend_cnt != MAX)) begin
      w_cnt_nxt = r_pend_cnt + CNT_W'(1);
    end else if (w_accept && !w_edge) begin
      w_cnt_nxt = r_pend_cnt - CNT_W'(1);
    end
  end

  // ARM holds off edge detection until the synchronizer and tgl_p reflect the settled input level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ARM;
      r_sync      <= '0;
      r_tgl_p     <= 1'b0;
      r_arm_cnt   <= '0;
      r_pend_cnt  <= '0;
      r_evt_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], tgl_in};
      r_tgl_p     <= w_tgl_s;
      r_pend_cnt  <= w_cnt_nxt;
      r_evt_valid <= (w_cnt_nxt != '0);

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end

      case (r_state)
        ST_ARM: begin
          if (r_arm_cnt == ARM_W'(SYNC_STAGES)) begin
            r_state <= ST_IDLE;
          end else begin
            r_arm_cnt <= r_arm_cnt + ARM_W'(1);
          end
        end
        default: begin
          if (w_cnt_nxt == MAX) begin
            r_state <= ST_FULL;
          end else if (w_cnt_nxt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_PEND;
          end
        end
      endcase
    end
  end

  assign evt_valid = r_evt_valid;
  assign pend_cnt  = r_pend_cnt;
  assign overflow  = r_overflow;
  assign state     = r_state;

`ifdef TOGGLE_DEC_ASSERT_EN
  a_valid_matches_cnt: assert property (@(posedge clk) disable iff (rst)
    r_evt_valid == (r_pend_cnt != '0));

  a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
    r_pend_cnt <= MAX);

  a_full_iff_max: assert property (@(posedge clk) disable iff (rst)
    (r_state != ST_ARM) |-> ((r_state == ST_FULL) == (r_pend_cnt == MAX)));

  a_no_edge_in_arm: assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_ARM) |-> ((r_pend_cnt == '0) && !w_edge));

  a_ovf_only_from_full: assert property (@(posedge clk) disable iff (rst)
    ((r_state != ST_FULL) && !r_overflow) |=> !r_overflow);
`else
`endif

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder (SYNC_STAGES=2, CNT_W=4): vector table plus
// hand-written fill/drain, overflow and reset sequences.
module tb_toggle_decoder;

  localparam logic [1:0] ARM  = 2'b00;
  localparam logic [1:0] IDLE = 2'b01;
  localparam logic [1:0] PEND = 2'b10;
  localparam logic [1:0] FULL = 2'b11;

  logic       clk;
  logic       rst;
  logic       tgl_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] pend_cnt;
  logic       overflow;
  logic       ovf_clr;
  logic [1:0] state;

  typedef struct {
    logic       rst;
    logic       tgl;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [3:0] ec;
    logic       eo;
    logic [1:0] es;
  } vec_t;

  vec_t tbl[$];
  int   n_pass;
  int   n_total;
  logic lvl;

  toggle_decoder #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgl_in    (tgl_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pend_cnt  (pend_cnt),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic t, input logic y, input logic c,
                              input logic ev, input logic [3:0] ec, input logic eo,
                              input logic [1:0] es);
    vec_t v;
    v.rst = r; v.tgl = t; v.rdy = y; v.clr = c;
    v.ev = ev; v.ec = ec; v.eo = eo; v.es = es;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic toggles(input int n);
    for (int i = 0; i < n; i++) begin
      lvl    = ~lvl;
      tgl_in = lvl;
      step();
    end
  endtask

  task automatic chk(input string name, input logic ev, input logic [3:0] ec,
                     input logic eo, input logic [1:0] es);
    n_total++;
    if ({evt_valid, pend_cnt, overflow, state} === {ev, ec, eo, es}) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got valid=%0b cnt=%0d ovf=%0b state=%02b, want valid=%0b cnt=%0d ovf=%0b state=%02b",
               name, evt_valid, pend_cnt, overflow, state, ev, ec, eo, es);
    end
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    tgl_in    = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    //            rst  tgl  rdy  clr   valid cnt  ovf  state
    tbl.push_back(mk(1, 1, 0, 0,  0, 4'd0, 0, ARM));   // reset held 3 cycles, tgl_in high
    tbl.push_back(mk(1, 1, 0, 0,  0, 4'd0, 0, ARM));
    tbl.push_back(mk(1, 1, 0, 0,  0, 4'd0, 0, ARM));
    tbl.push_back(mk(0, 1, 0, 0,  0, 4'd0, 0, ARM));   // ARM lasts 3 cycles after release
    tbl.push_back(mk(0, 1, 0, 0,  0, 4'd0, 0, ARM));
    tbl.push_back(mk(0, 1, 0, 0,  0, 4'd0, 0, IDLE));
    tbl.push_back(mk(0, 1, 0, 0,  0, 4'd0, 0, IDLE));  // initial high level is not an event
    tbl.push_back(mk(0, 0, 0, 0,  0, 4'd0, 0, IDLE));  // capture edge k
    tbl.push_back(mk(0, 0, 0, 0,  0, 4'd0, 0, IDLE));  // k+1
    tbl.push_back(mk(0, 0, 0, 0,  1, 4'd1, 0, PEND));  // k+2: valid
    tbl.push_back(mk(0, 0, 0, 0,  1, 4'd1, 0, PEND));
    tbl.push_back(mk(0, 0, 1, 0,  0, 4'd0, 0, IDLE));  // one accept
    tbl.push_back(mk(0, 0, 1, 0,  0, 4'd0, 0, IDLE));  // ready with nothing pending
    tbl.push_back(mk(0, 1, 0, 0,  0, 4'd0, 0, IDLE));  // two back-to-back toggles
    tbl.push_back(mk(0, 0, 0, 0,  0, 4'd0, 0, IDLE));
    tbl.push_back(mk(0, 0, 0, 0,  1, 4'd1, 0, PEND));
    tbl.push_back(mk(0, 0, 0, 0,  1, 4'd2, 0, PEND));
    tbl.push_back(mk(0, 0, 0, 0,  1, 4'd2, 0, PEND));
    tbl.push_back(mk(0, 1, 0, 0,  1, 4'd2, 0, PEND));  // toggle timed to meet an accept
    tbl.push_back(mk(0, 1, 0, 0,  1, 4'd2, 0, PEND));
    tbl.push_back(mk(0, 1, 1, 0,  1, 4'd2, 0, PEND));  // edge + accept cancel
    tbl.push_back(mk(0, 1, 1, 0,  1, 4'd1, 0, PEND));
    tbl.push_back(mk(0, 1, 1, 0,  0, 4'd0, 0, IDLE));
    tbl.push_back(mk(0, 1, 0, 1,  0, 4'd0, 0, IDLE));  // clear with no overflow set

    foreach (tbl[i]) begin
      rst       = tbl[i].rst;
      tgl_in    = tbl[i].tgl;
      evt_ready = tbl[i].rdy;
      ovf_clr   = tbl[i].clr;
      step();
      chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ec, tbl[i].eo, tbl[i].es);
    end
    ovf_clr   = 1'b0;
    evt_ready = 1'b0;
    lvl       = 1'b1;
    tgl_in    = lvl;

    // 17 successive toggles saturate at 15 and drop two events.
    toggles(17);
    idle_steps(3);
    chk("fill17", 1'b1, 4'd15, 1'b1, FULL);
    evt_ready = 1'b1;
    step();
    chk("full_to_pend", 1'b1, 4'd14, 1'b1, PEND);
    idle_steps(14);
    chk("drain", 1'b0, 4'd0, 1'b1, IDLE);
    evt_ready = 1'b0;
    ovf_clr   = 1'b1;
    step();
    ovf_clr   = 1'b0;
    chk("ovf_clr", 1'b0, 4'd0, 1'b0, IDLE);

    // Edge and accept in the same cycle while full.
    toggles(15);
    idle_steps(3);
    chk("fill15", 1'b1, 4'd15, 1'b0, FULL);
    toggles(1);
    step();
    evt_ready = 1'b1;
    step();
    chk("edge_accept_full", 1'b1, 4'd15, 1'b0, FULL);
    evt_ready = 1'b0;
    step();
    chk("hold_full", 1'b1, 4'd15, 1'b0, FULL);

    // A drop in the same cycle as ovf_clr leaves overflow set.
    ovf_clr = 1'b1;
    toggles(1);
    step();
    step();
    chk("drop_beats_clr", 1'b1, 4'd15, 1'b1, FULL);
    ovf_clr = 1'b0;

    evt_ready = 1'b1;
    idle_steps(10);
    evt_ready = 1'b0;
    chk("cnt5", 1'b1, 4'd5, 1'b1, PEND);

    // Reset mid-operation with an edge in flight and competing inputs.
    toggles(1);
    rst       = 1'b1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    step();
    chk("rst_mid", 1'b0, 4'd0, 1'b0, ARM);
    rst       = 1'b0;
    evt_ready = 1'b0;
    step();
    chk("rearm1", 1'b0, 4'd0, 1'b0, ARM);
    step();
    chk("rearm2", 1'b0, 4'd0, 1'b0, ARM);
    step();
    chk("rearm_idle", 1'b0, 4'd0, 1'b0, IDLE);
    idle_steps(3);
    chk("no_stale_evt", 1'b0, 4'd0, 1'b0, IDLE);

    // A fresh toggle after re-arm is still decoded.
    toggles(1);
    idle_steps(2);
    chk("post_rst_evt", 1'b1, 4'd1, 1'b0, PEND);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
